// File: rtl/stump_control_fsm_if.sv
// Stump control sequencer bus: instruction/flag/handshake inputs to the
// sequencer and every control strobe it drives into the datapath.
// master = the sequencer, slave = the datapath side (register bank, ALU, memory).
interface stump_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      ir;
    logic [3:0]       cc;
    logic             mem_ready;
    logic [1:0]       state;
    logic             ir_en;
    logic             reg_write;
    logic [2:0]       write_addr;
    logic [1:0]       wsel;
    logic             mem_ren;
    logic             mem_wen;
    logic             addr_sel;
    logic             addr_en;
    logic             cc_en;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  ir, cc, mem_ready,
        output state, ir_en, reg_write, write_addr, wsel,
               mem_ren, mem_wen, addr_sel, addr_en, cc_en, instr_count
    );

    modport slave (
        output ir, cc, mem_ready,
        input  state, ir_en, reg_write, write_addr, wsel,
               mem_ren, mem_wen, addr_sel, addr_en, cc_en, instr_count
    );
endinterface

// File: rtl/stump_control_fsm.sv
// Stump control sequencer: steps FETCH -> EXECUTE (-> MEMORY) -> FETCH and
// drives register-bank writes, memory strobes, IR/address latches and CC update.
// All control outputs are combinational from the registered state and the
// current ir/cc/mem_ready; only state and instr_count are registers.
// Optional build macro STUMP_SINGLE_STEP_EN adds a 'step' input that gates
// completion of FETCH for debugger single-stepping.
module stump_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef STUMP_SINGLE_STEP_EN
    input  logic step,
`endif
    stump_control_fsm_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [1:0] WSEL_PC  = 2'b00;
    localparam logic [1:0] WSEL_ALU = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;
    localparam logic [2:0] REG_PC   = 3'd7;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    logic       ir_en;
    logic       reg_write;
    logic [2:0] write_addr;
    logic [1:0] wsel;
    logic       mem_ren;
    logic       mem_wen;
    logic       addr_sel;
    logic       addr_en;
    logic       cc_en;

    logic [2:0] op;
    logic       is_store;
    logic [2:0] dst;
    logic [3:0] cond;
    logic       fetch_go;
    logic       unused_ir;

    assign op        = bus.ir[15:13];
    assign is_store  = bus.ir[11];
    assign dst       = bus.ir[10:8];
    assign cond      = bus.ir[11:8];
    assign unused_ir = ^{bus.ir[12], bus.ir[7:0]};

`ifdef STUMP_SINGLE_STEP_EN
    assign fetch_go = bus.mem_ready & step;
`else
    assign fetch_go = bus.mem_ready;
`endif

    // Branch condition evaluation; flags are ordered {N,Z,V,C}.
    function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c)
            4'h0:    cond_met = 1'b1;
            4'h1:    cond_met = 1'b0;
            4'h2:    cond_met = !cy && !z;
            4'h3:    cond_met = cy || z;
            4'h4:    cond_met = !cy;
            4'h5:    cond_met = cy;
            4'h6:    cond_met = !z;
            4'h7:    cond_met = z;
            4'h8:    cond_met = !v;
            4'h9:    cond_met = v;
            4'hA:    cond_met = !n;
            4'hB:    cond_met = n;
            4'hC:    cond_met = (n == v);
            4'hD:    cond_met = (n != v);
            4'hE:    cond_met = !z && (n == v);
            default: cond_met = z || (n != v);
        endcase
    endfunction

    // Next-state and control decode; reset overrides every strobe and select.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        ir_en      = 1'b0;
        reg_write  = 1'b0;
        write_addr = 3'd0;
        wsel       = WSEL_PC;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        addr_sel   = 1'b0;
        addr_en    = 1'b0;
        cc_en      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_ren  = 1'b1;
                addr_sel = 1'b0;
                if (fetch_go) begin
                    ir_en      = 1'b1;
                    reg_write  = 1'b1;
                    write_addr = REG_PC;
                    wsel       = WSEL_PC;
                    state_d    = EXECUTE;
                end
            end
            EXECUTE: begin
                if (op <= 3'b101) begin
                    reg_write  = 1'b1;
                    write_addr = dst;
                    wsel       = WSEL_ALU;
                    cc_en      = bus.ir[11];
                    retire     = 1'b1;
                    state_d    = FETCH;
                end else if (op == 3'b110) begin
                    addr_en = 1'b1;
                    state_d = MEMORY;
                end else begin
                    if (cond_met(cond, bus.cc)) begin
                        reg_write  = 1'b1;
                        write_addr = REG_PC;
                        wsel       = WSEL_ALU;
                    end
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEMORY: begin
                addr_sel = 1'b1;
                mem_ren  = !is_store;
                mem_wen  = is_store;
                if (bus.mem_ready) begin
                    if (!is_store) begin
                        reg_write  = 1'b1;
                        write_addr = dst;
                        wsel       = WSEL_MEM;
                    end
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (rst) begin
            retire     = 1'b0;
            ir_en      = 1'b0;
            reg_write  = 1'b0;
            write_addr = 3'd0;
            wsel       = WSEL_PC;
            mem_ren    = 1'b0;
            mem_wen    = 1'b0;
            addr_sel   = 1'b0;
            addr_en    = 1'b0;
            cc_en      = 1'b0;
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.ir_en       = ir_en;
    assign bus.reg_write   = reg_write;
    assign bus.write_addr  = write_addr;
    assign bus.wsel        = wsel;
    assign bus.mem_ren     = mem_ren;
    assign bus.mem_wen     = mem_wen;
    assign bus.addr_sel    = addr_sel;
    assign bus.addr_en     = addr_en;
    assign bus.cc_en       = cc_en;
    assign bus.instr_count = count_q;

endmodule
